// File: rtl/param_alu_pkg.sv
// param_alu_pkg: shared definitions for the parameterised ALU.
//   op_t   - 2-bit operation select
//   OP_ADD - 0, OP_SUB - 1, OP_AND - 2, OP_XOR - 3
package param_alu_pkg;

    typedef logic [1:0] op_t;

    localparam op_t OP_ADD = 2'd0;
    localparam op_t OP_SUB = 2'd1;
    localparam op_t OP_AND = 2'd2;
    localparam op_t OP_XOR = 2'd3;

endpackage

// File: rtl/param_alu_if.sv
// param_alu_if: operand/result bundle for param_alu.
//   valid_in, op, A, B              - request side, driven by the master
//   C, valid_out, carry_out, ovf    - registered result side, driven by the slave (ALU)
// WIDTH must match the WIDTH of the param_alu instance it connects to.
interface param_alu_if #(
    parameter int unsigned WIDTH = 32
) ();
    import param_alu_pkg::*;

    logic             valid_in;
    op_t              op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] C;
    logic             valid_out;
    logic             carry_out;
    logic             ovf;

    modport master (
        output valid_in, op, A, B,
        input  C, valid_out, carry_out, ovf
    );

    modport slave (
        input  valid_in, op, A, B,
        output C, valid_out, carry_out, ovf
    );

endinterface

// File: rtl/param_alu_core.sv
// param_alu_core: purely combinational result/flag computation.
//   op    - operation select (ADD, SUB, AND, XOR)
//   a, b  - unsigned operands, WIDTH bits
//   c     - result, WIDTH bits
//   carry - ADD: carry out of MSB; SUB: unsigned borrow (a < b); logic ops: 0
//   ovf   - signed overflow for ADD/SUB; 0 for logic ops
// Build option: PARAM_ALU_SAT_EN makes ADD/SUB saturate unsigned (carry -> all-ones,
// borrow -> zero); carry and ovf still describe the unsaturated result.
module param_alu_core
    import param_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  op_t              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic             carry,
    output logic             ovf
);

    localparam int unsigned Msb = WIDTH - 1;

    // One extra bit: sum[WIDTH] is the carry, diff[WIDTH] is set exactly when a < b.
    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        c     = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        case (op)
            OP_ADD: begin
                c     = sum[WIDTH-1:0];
                carry = sum[WIDTH];
                ovf   = (a[Msb] == b[Msb]) && (sum[Msb] != a[Msb]);
`ifdef PARAM_ALU_SAT_EN
                if (sum[WIDTH]) begin
                    c = '1;
                end
`endif
            end
            OP_SUB: begin
                c     = diff[WIDTH-1:0];
                carry = diff[WIDTH];
                ovf   = (a[Msb] != b[Msb]) && (diff[Msb] != a[Msb]);
`ifdef PARAM_ALU_SAT_EN
                if (diff[WIDTH]) begin
                    c = '0;
                end
`endif
            end
            OP_AND:  c = a & b;
            OP_XOR:  c = a ^ b;
            default: c = '0;
        endcase
    end

endmodule

// File: rtl/param_alu.sv
// param_alu: registered two-operand ALU, one cycle of latency, no backpressure.
//   clk - rising-edge clock
//   rst - asynchronous active-high reset; clears C, valid_out, carry_out, ovf
//   bus - param_alu_if slave: valid_in/op/A/B in, C/valid_out/carry_out/ovf out
// WIDTH: operand/result width, 2..64. Build option PARAM_ALU_SAT_EN (see param_alu_core).
// When valid_in is low the result registers hold and valid_out drops for that cycle.
module param_alu
    import param_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    param_alu_if.slave  bus
);

    logic [WIDTH-1:0] c_d;
    logic             carry_d;
    logic             ovf_d;

    logic [WIDTH-1:0] c_q;
    logic             carry_q;
    logic             ovf_q;
    logic             valid_q;

    param_alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op    (bus.op),
        .a     (bus.A),
        .b     (bus.B),
        .c     (c_d),
        .carry (carry_d),
        .ovf   (ovf_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_q     <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= bus.valid_in;
            if (bus.valid_in) begin
                c_q     <= c_d;
                carry_q <= carry_d;
                ovf_q   <= ovf_d;
            end
        end
    end

    assign bus.C         = c_q;
    assign bus.carry_out = carry_q;
    assign bus.ovf       = ovf_q;
    assign bus.valid_out = valid_q;

endmodule

// File: tb/tb_param_alu.sv
// Bench for param_alu at WIDTH=32 and WIDTH=16 side by side.
module tb_param_alu;
    import param_alu_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    // Expected outputs per instance: index 0 = WIDTH 32, index 1 = WIDTH 16.
    logic [63:0] exp_c  [2];
    logic        exp_cy [2];
    logic        exp_ov [2];
    logic        exp_v  [2];

    param_alu_if #(.WIDTH(32)) bus32 ();
    param_alu_if #(.WIDTH(16)) bus16 ();

    param_alu #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
    param_alu #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Arithmetic reference: signed overflow judged by whether the true signed result fits.
    function automatic void model(input int w, input logic [1:0] op, input longint unsigned a,
                                  input longint unsigned b, output logic [63:0] c,
                                  output logic cy, output logic ov);
        longint unsigned mask;
        longint          half;
        longint          sa;
        longint          sb;
        longint          r;
        mask = (64'd1 << w) - 64'd1;
        half = longint'(64'd1 << (w - 1));
        sa   = (a >= longint'(half)) ? longint'(a) - 2 * half : longint'(a);
        sb   = (b >= longint'(half)) ? longint'(b) - 2 * half : longint'(b);
        c    = 64'd0;
        cy   = 1'b0;
        ov   = 1'b0;
        case (op)
            2'd0: begin
                c  = (a + b) & mask;
                cy = (a + b) > mask;
                r  = sa + sb;
                ov = (r >= half) || (r < -half);
`ifdef PARAM_ALU_SAT_EN
                if (cy) c = mask;
`endif
            end
            2'd1: begin
                c  = (a - b) & mask;
                cy = a < b;
                r  = sa - sb;
                ov = (r >= half) || (r < -half);
`ifdef PARAM_ALU_SAT_EN
                if (cy) c = 64'd0;
`endif
            end
            2'd2:    c = a & b;
            default: c = a ^ b;
        endcase
    endfunction

    function automatic longint unsigned rand_operand(input int w);
        longint unsigned mask;
        mask = (64'd1 << w) - 64'd1;
        case ($urandom_range(0, 5))
            0:       return 64'd0;
            1:       return mask;
            2:       return 64'd1 << (w - 1);
            3:       return (64'd1 << (w - 1)) - 64'd1;
            default: return {32'd0, $urandom} & mask;
        endcase
    endfunction

    // Drive one cycle on instance of width w (the other idles), update expectations,
    // then return 1 ns after the capturing edge.
    task automatic drive(input int w, input bit v, input logic [1:0] op,
                         input longint unsigned a, input longint unsigned b);
        int idx;
        idx = (w == 32) ? 0 : 1;
        @(negedge clk);
        bus32.valid_in = (w == 32) && v;
        bus16.valid_in = (w == 16) && v;
        if (w == 32) begin
            bus32.op = op; bus32.A = a[31:0]; bus32.B = b[31:0];
        end else begin
            bus16.op = op; bus16.A = a[15:0]; bus16.B = b[15:0];
        end
        exp_v[0] = 1'b0;
        exp_v[1] = 1'b0;
        if (v) begin
            model(w, op, a, b, exp_c[idx], exp_cy[idx], exp_ov[idx]);
            exp_v[idx] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic observe(input int idx, output logic [63:0] c, output logic [2:0] fl);
        if (idx == 0) begin
            c  = {32'd0, bus32.C};
            fl = {bus32.valid_out, bus32.carry_out, bus32.ovf};
        end else begin
            c  = {48'd0, bus16.C};
            fl = {bus16.valid_out, bus16.carry_out, bus16.ovf};
        end
    endtask

    task automatic clear_expect();
        for (int i = 0; i < 2; i++) begin
            exp_c[i] = 64'd0; exp_cy[i] = 1'b0; exp_ov[i] = 1'b0; exp_v[i] = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic [63:0] c;
        logic [2:0]  fl;
        #2;
        rst = 1'b1;
        #1;
        clear_expect();
        for (int i = 0; i < 2; i++) begin
            observe(i, c, fl);
            n_checks++;
            if (c !== 64'd0) begin
                n_fail++;
                $display("FAIL reset_c[%0d]: got %h want 0", i, c);
            end
            n_checks++;
            if (fl !== 3'b000) begin
                n_fail++;
                $display("FAIL reset_flags[%0d]: got %b want 000", i, fl);
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        int          w;
        logic [1:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] c;
        logic [2:0]  fl;  // {valid_out, carry_out, ovf}
    } vec_t;

    task automatic test_directed();
        vec_t        v [8];
        logic [63:0] c;
        logic [2:0]  fl;
        v[0] = '{32, OP_ADD, 64'h1, 64'h12, 64'h13, 3'b100};
`ifdef PARAM_ALU_SAT_EN
        v[1] = '{16, OP_ADD, 64'hFFFF, 64'h1, 64'hFFFF, 3'b110};
        v[2] = '{32, OP_SUB, 64'h1, 64'h12, 64'h0, 3'b110};
        v[7] = '{32, OP_ADD, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 3'b110};
`else
        v[1] = '{16, OP_ADD, 64'hFFFF, 64'h1, 64'h0, 3'b110};
        v[2] = '{32, OP_SUB, 64'h1, 64'h12, 64'hFFFF_FFEF, 3'b110};
        v[7] = '{32, OP_ADD, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE, 3'b110};
`endif
        v[3] = '{16, OP_ADD, 64'h7FFF, 64'h1, 64'h8000, 3'b101};
        v[4] = '{16, OP_AND, 64'hF0F0, 64'hFF00, 64'hF000, 3'b100};
        v[5] = '{16, OP_XOR, 64'hF0F0, 64'hFF00, 64'h0FF0, 3'b100};
        v[6] = '{32, OP_SUB, 64'h8000_0000, 64'h1, 64'h7FFF_FFFF, 3'b101};
        for (int i = 0; i < 8; i++) begin
            drive(v[i].w, 1'b1, v[i].op, v[i].a, v[i].b);
            observe((v[i].w == 32) ? 0 : 1, c, fl);
            n_checks++;
            if (c !== v[i].c) begin
                n_fail++;
                $display("FAIL directed_c[%0d]: got %h want %h", i, c, v[i].c);
            end
            n_checks++;
            if (fl !== v[i].fl) begin
                n_fail++;
                $display("FAIL directed_flags[%0d]: got %b want %b", i, fl, v[i].fl);
            end
        end
    endtask

    task automatic test_hold_back_to_back();
        logic [63:0] c;
        logic [2:0]  fl;
        drive(16, 1'b1, OP_SUB, rand_operand(16), rand_operand(16));
        for (int i = 0; i < 3; i++) begin
            drive(16, 1'b0, OP_ADD, rand_operand(16), rand_operand(16));
            observe(1, c, fl);
            n_checks++;
            if (c !== exp_c[1] || fl !== {1'b0, exp_cy[1], exp_ov[1]}) begin
                n_fail++;
                $display("FAIL hold[%0d]: got %h/%b want %h/%b", i, c, fl, exp_c[1],
                         {1'b0, exp_cy[1], exp_ov[1]});
            end
        end
        for (int i = 0; i < 4; i++) begin
            drive(32, 1'b1, 2'($urandom_range(0, 3)), rand_operand(32), rand_operand(32));
            observe(0, c, fl);
            n_checks++;
            if (c !== exp_c[0] || fl !== {1'b1, exp_cy[0], exp_ov[0]}) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: got %h/%b want %h/%b", i, c, fl, exp_c[0],
                         {1'b1, exp_cy[0], exp_ov[0]});
            end
        end
    endtask

    task automatic test_random();
        logic [63:0] c;
        logic [2:0]  fl;
        int          w;
        for (int n = 0; n < 300; n++) begin
            w = ($urandom_range(0, 1) == 0) ? 32 : 16;
            drive(w, ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                  rand_operand(w), rand_operand(w));
            for (int i = 0; i < 2; i++) begin
                observe(i, c, fl);
                n_checks++;
                if (c !== exp_c[i] || fl !== {exp_v[i], exp_cy[i], exp_ov[i]}) begin
                    n_fail++;
                    $display("FAIL random[%0d] w%0d: got %h/%b want %h/%b", n,
                             (i == 0) ? 32 : 16, c, fl, exp_c[i],
                             {exp_v[i], exp_cy[i], exp_ov[i]});
                end
            end
        end
    endtask

    task automatic test_midstream_reset();
        logic [63:0] c;
        logic [2:0]  fl;
        drive(32, 1'b1, OP_ADD, 64'hFFFF_FFFF, 64'h5);
        // Launch a new operation, then reset before its capturing edge.
        @(negedge clk);
        bus32.valid_in = 1'b1;
        bus32.op       = OP_XOR;
        bus32.A        = 32'hDEAD_BEEF;
        bus32.B        = 32'h1234_5678;
        #2;
        rst = 1'b1;
        #1;
        clear_expect();
        observe(0, c, fl);
        n_checks++;
        if (c !== 64'd0 || fl !== 3'b000) begin
            n_fail++;
            $display("FAIL midreset_immediate: got %h/%b want 0/000", c, fl);
        end
        @(posedge clk);
        #1;
        observe(0, c, fl);
        n_checks++;
        if (c !== 64'd0 || fl !== 3'b000) begin
            n_fail++;
            $display("FAIL midreset_discard: got %h/%b want 0/000", c, fl);
        end
        @(negedge clk);
        rst = 1'b0;
        drive(32, 1'b1, OP_AND, 64'hFF00_FF00, 64'h0FF0_0FF0);
        observe(0, c, fl);
        n_checks++;
        if (c !== 64'h0F00_0F00 || fl !== 3'b100) begin
            n_fail++;
            $display("FAIL midreset_resume: got %h/%b want 0f000f00/100", c, fl);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        bus32.valid_in = 1'b0; bus32.op = OP_ADD; bus32.A = '0; bus32.B = '0;
        bus16.valid_in = 1'b0; bus16.op = OP_ADD; bus16.A = '0; bus16.B = '0;
        clear_expect();
        test_reset();
        test_directed();
        test_hold_back_to_back();
        test_random();
        test_midstream_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/param_alu.md
Name: param_alu

Overview:
- Width-parameterized, registered two-operand arithmetic/logic unit. Computes C from A and B with one clock of latency.
- Reusable leaf block: the same RTL is instantiated at several datapath widths, e.g. WIDTH=32 and WIDTH=16.
- Provides valid-qualified results plus carry/overflow flags for downstream logic.

Parameters:
- WIDTH, 32, operand and result width in bits; legal range 2..64.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- valid_in  input  1  A, B and op are sampled on this clock edge when high.
- op  input  2  operation select: 0=ADD, 1=SUB, 2=AND, 3=XOR.
- A  input  WIDTH  operand A, unsigned.
- B  input  WIDTH  operand B, unsigned.
- C  output  WIDTH  registered result.
- valid_out  output  1  C and flags hold a new result this cycle.
- carry_out  output  1  ADD: carry out of the MSB. SUB: borrow (A<B). Logic ops: 0.
- ovf  output  1  signed overflow for ADD/SUB; 0 for logic ops.

Behaviour:
- Reset (asynchronous assert, synchronous release): C=0, valid_out=0, carry_out=0, ovf=0.
- Latency is exactly 1 cycle. Operands sampled at edge N with valid_in=1 give the result at C after edge N; valid_out=1 for that one cycle.
- valid_in=0 at an edge: valid_out goes to 0 and C/carry_out/ovf hold their previous values.
- Back-to-back valid_in gives a new result every cycle; there is no backpressure.
- ADD: C = (A+B) mod 2^WIDTH; carry_out = bit WIDTH of the (WIDTH+1)-bit sum.
- SUB: C = (A-B) mod 2^WIDTH; carry_out = 1 when A<B (unsigned borrow).
- ovf: for ADD, set when A and B have the same MSB and C's MSB differs. For SUB, set when A and B MSBs differ and C's MSB differs from A's.
- AND/XOR: bitwise, full width.
- Wrap-around: all-ones + 1 under ADD gives C=0, carry_out=1.
- Reset asserted mid-stream clears the outputs immediately; any in-flight result is discarded.

Optional Feature:
- Macro PARAM_ALU_SAT_EN.
- Defined: ADD/SUB saturate unsigned. ADD with carry gives C = all-ones; SUB with borrow gives C = 0. carry_out and ovf still report the raw, unsaturated condition.
- Undefined: modular wrap as described in Behaviour. No saturation logic is synthesized.

Decomposition:
- Shared package param_alu_pkg: op encoding constants (OP_ADD=0, OP_SUB=1, OP_AND=2, OP_XOR=3) and a 2-bit op typedef.
- Optional sub-module param_alu_core: purely combinational result/flag computation. The top level holds only the output registers and the valid pipeline.

Test Plan:
- Reset: assert rst with no clock edge -> C=0, valid_out=0, carry_out=0, ovf=0 immediately.
- WIDTH=32, ADD, A=0x00000001, B=0x00000012, valid_in=1 -> next cycle C=0x00000013, valid_out=1, carry_out=0, ovf=0.
- WIDTH=16, ADD, A=0xFFFF, B=0x0001 -> C=0x0000, carry_out=1, ovf=0. With PARAM_ALU_SAT_EN defined -> C=0xFFFF, carry_out=1.
- WIDTH=32, SUB, A=0x00000001, B=0x00000012 -> C=0xFFFFFFEF, carry_out=1. With SAT_EN -> C=0.
- WIDTH=16, ADD, A=0x7FFF, B=0x0001 -> C=0x8000, ovf=1. Then AND, A=0xF0F0, B=0xFF00 -> C=0xF000. Then XOR, same operands -> C=0x0FF0.
- Hold: valid_in=0 for 3 cycles after a result -> C unchanged, valid_out=0. Then 4 back-to-back valid ops -> 4 consecutive results with valid_out=1.
